// File: rtl/i2c_dac_scheduler_if.sv
// Bus bundle between the i2c_dac_scheduler and its neighbours.
//   Request side : req_a/data_a, req_b/data_b from the register-decode layer.
//   Master side  : fifo_in/fifo_wr/start to the I2C master, i2c_ended/i2c_ack back.
//   Status       : busy, done_a/done_b with ok.
// Modport master is the scheduler's view; slave is the environment's view.
interface i2c_dac_scheduler_if;
  logic        req_a;
  logic [11:0] data_a;
  logic        req_b;
  logic [11:0] data_b;
  logic [7:0]  fifo_in;
  logic        fifo_wr;
  logic        start;
  logic        i2c_ended;
  logic        i2c_ack;
  logic        busy;
  logic        done_a;
  logic        done_b;
  logic        ok;

  modport master (
    input  req_a, data_a, req_b, data_b, i2c_ended, i2c_ack,
    output fifo_in, fifo_wr, start, busy, done_a, done_b, ok
  );

  modport slave (
    output req_a, data_a, req_b, data_b, i2c_ended, i2c_ack,
    input  fifo_in, fifo_wr, start, busy, done_a, done_b, ok
  );
endinterface

// File: rtl/i2c_dac_scheduler.sv
// Round-robin scheduler that turns 12-bit DAC updates from two channels into
// 3-byte I2C frames, launches the shared master and retries on NACK/timeout.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - i2c_dac_scheduler_if.master (requests, FIFO/start, completion, status)
module i2c_dac_scheduler #(
  parameter logic [6:0]  DEV_ADDR       = 7'h60,
  parameter logic [3:0]  CMD_A          = 4'h0,
  parameter logic [3:0]  CMD_B          = 4'h1,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned RETRY_GAP      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   rst,
  i2c_dac_scheduler_if.master   bus
);

  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned GAP_W   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]  ADDR_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_t;

  state_t               state;
  logic                 pending_a, pending_b;
  logic [11:0]          value_a, value_b;
  logic [11:0]          shadow;
  logic                 sel;
  logic                 prefer_b;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [1:0]           byte_idx;

  logic [7:0]           fifo_in;
  logic                 fifo_wr, start, busy, done_a, done_b, ok;

  logic                 pick_a, pick_b, attempt_ok, attempt_fail;

  // Arbitration and attempt outcome; a completion pulse beats a same-cycle timeout.
  always_comb begin
    pick_a       = (state == S_IDLE) && pending_a && (!pending_b || !prefer_b);
    pick_b       = (state == S_IDLE) && pending_b && !pick_a;
    attempt_ok   = (state == S_WAIT) && bus.i2c_ended && bus.i2c_ack;
    attempt_fail = (state == S_WAIT) &&
                   ((bus.i2c_ended && !bus.i2c_ack) ||
                    (!bus.i2c_ended && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))));
  end

  // Request capture; a new request in the cycle its pending bit is consumed wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_a <= 1'b0;
      pending_b <= 1'b0;
      value_a   <= '0;
      value_b   <= '0;
    end else begin
      pending_a <= bus.req_a | (pending_a & ~pick_a);
      pending_b <= bus.req_b | (pending_b & ~pick_b);
      if (bus.req_a) value_a <= bus.data_a;
      if (bus.req_b) value_b <= bus.data_b;
    end
  end

  // Sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      shadow    <= '0;
      sel       <= 1'b0;
      prefer_b  <= 1'b0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      byte_idx  <= '0;
      fifo_in   <= '0;
      fifo_wr   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      ok        <= 1'b0;
    end else begin
      fifo_in <= '0;
      fifo_wr <= 1'b0;
      start   <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      ok      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_a || pick_b) begin
            shadow    <= pick_b ? value_b : value_a;
            sel       <= pick_b;
            retry_cnt <= '0;
            byte_idx  <= '0;
            fifo_wr   <= 1'b1;
            fifo_in   <= ADDR_BYTE;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          // byte0 went out on entry; byte_idx tracks what is on the bus now.
          case (byte_idx)
            2'd0: begin
              fifo_wr  <= 1'b1;
              fifo_in  <= {sel ? CMD_B : CMD_A, shadow[11:8]};
              byte_idx <= 2'd1;
            end
            2'd1: begin
              fifo_wr  <= 1'b1;
              fifo_in  <= shadow[7:0];
              byte_idx <= 2'd2;
            end
            default: begin
              start <= 1'b1;
              state <= S_START;
            end
          endcase
        end
        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (attempt_ok || (attempt_fail && (retry_cnt >= RETRY_W'(MAX_RETRIES)))) begin
            done_a   <= ~sel;
            done_b   <= sel;
            ok       <= attempt_ok;
            prefer_b <= ~sel;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (attempt_fail) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            gap_cnt   <= '0;
            state     <= S_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(RETRY_GAP - 1)) begin
            byte_idx <= '0;
            fifo_wr  <= 1'b1;
            fifo_in  <= ADDR_BYTE;
            state    <= S_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_in = fifo_in;
  assign bus.fifo_wr = fifo_wr;
  assign bus.start   = start;
  assign bus.busy    = busy;
  assign bus.done_a  = done_a;
  assign bus.done_b  = done_b;
  assign bus.ok      = ok;

endmodule
